// File: rtl/phase_frame_loader.sv
// phase_frame_loader: parses framed 16-channel phase tables from the host byte
// stream into a shadow bank, then commits the whole table to the phase
// generator on a carrier-period boundary so every channel retargets together.
// Optional build macro PHASE_CKSUM_EN adds a trailing XOR checksum byte per frame.
module phase_frame_loader #(
   parameter int unsigned N_CH    = 16,
   parameter logic [7:0]  HDR     = 8'hAA,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              period_tick,
   output logic [8*N_CH-1:0] phase_out,
   output logic              phase_upd,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StPayload = 2'd1;
`ifdef PHASE_CKSUM_EN
   localparam logic [1:0] StCksum   = 2'd2;
`endif
   localparam logic [1:0] StPend    = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [N_CH-1:0][7:0]   shadow_q, shadow_d;
   logic [8*N_CH-1:0]      phase_q, phase_d;
   logic                   upd_q, upd_d;
   logic                   err_q, err_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
`ifdef PHASE_CKSUM_EN
   logic [7:0]             xor_q, xor_d;
`endif

   logic                   accept;
   logic [CntW-1:0]        cnt_inc;
   logic                   timeout_hit;

   assign accept      = in_valid && ready_q;
   assign cnt_inc     = cnt_q + 1'b1;
   // Fires in the same cycle the silence counter would reach TIMEOUT-1.
   assign timeout_hit = (cnt_inc == CntW'(TIMEOUT - 1));

   // Frame parser next-state: byte capture, timeout and commit decisions.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      phase_d  = phase_q;
      upd_d    = 1'b0;
      err_d    = 1'b0;
`ifdef PHASE_CKSUM_EN
      xor_d    = xor_q;
`endif
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (accept && (in_data == HDR)) begin
               idx_d   = '0;
`ifdef PHASE_CKSUM_EN
               xor_d   = 8'h00;
`endif
               state_d = StPayload;
            end
         end
         StPayload: begin
            if (accept) begin
               // HDR-valued bytes here are payload, never a resync.
               shadow_d[idx_q] = in_data;
`ifdef PHASE_CKSUM_EN
               xor_d           = xor_q ^ in_data;
`endif
               cnt_d           = '0;
               idx_d           = idx_q + 1'b1;
               if (idx_q == IdxW'(N_CH - 1)) begin
`ifdef PHASE_CKSUM_EN
                  state_d = StCksum;
`else
                  state_d = StPend;
`endif
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`ifdef PHASE_CKSUM_EN
         StCksum: begin
            if (accept) begin
               cnt_d = '0;
               if (in_data == xor_q) begin
                  state_d = StPend;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`endif
         StPend: begin
            cnt_d = '0;
            if (period_tick) begin
               phase_d = shadow_q;
               upd_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
      // Handshake and status are registered from the next state.
      ready_d = (state_d != StPend);
      busy_d  = (state_d != StIdle);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         phase_q  <= '0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
`ifdef PHASE_CKSUM_EN
         xor_q    <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         phase_q  <= phase_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
`ifdef PHASE_CKSUM_EN
         xor_q    <= xor_d;
`endif
      end
   end

   assign in_ready  = ready_q;
   assign phase_out = phase_q;
   assign phase_upd = upd_q;
   assign frame_err = err_q;
   assign busy      = busy_q;

endmodule

// File: doc/phase_frame_loader.md
# phase_frame_loader

Upstream control stage for the 4x4 ultrasonic transducer phase generator. It takes the byte stream from the host link (UART RX byte interface) and parses framed phase tables of 16 channel phase bytes into a shadow bank. It commits each complete, valid table to the generator's phase inputs only on a carrier-period boundary, so all 16 channels change focus in the same period, glitch-free.

## Interface
- `N_CH`, default 16: number of transducer channels. Channel k drives generator output wav(k/4)_(k%4).
- `HDR`, default 8'hAA: frame header byte.
- `TIMEOUT`, default 100000: allowed clock cycles of silence between bytes inside a frame (2 ms at 50 MHz).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  8  byte from host link.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte. A byte is taken on a cycle where `in_valid` and `in_ready` are both high.
- `period_tick`  in  1  one-cycle pulse from the generator at each carrier period start.
- `phase_out`  out  8*N_CH  committed phase table. Channel k is `phase_out[8k+7:8k]`; the value is the delay in units of 1/256 carrier period.
- `phase_upd`  out  1  one-cycle pulse in the cycle `phase_out` takes new values.
- `frame_err`  out  1  one-cycle pulse on a checksum failure or timeout.
- `busy`  out  1  high from header acceptance until commit or abort.

## Operation
- States: IDLE, PAYLOAD, CKSUM, PEND.
- **IDLE**
  - `in_ready`=1.
  - Accepted byte == `HDR`: clear byte index and running XOR, go to PAYLOAD.
  - Any other byte: dropped silently; no error.
- **PAYLOAD**
  - `in_ready`=1.
  - The byte accepted at index i is written to shadow[i], and the running XOR ^= byte.
  - Payload bytes equal to `HDR` are data, not a resync.
  - After index N_CH-1 is accepted, go to CKSUM (or to PEND, see Configuration).
- **CKSUM**
  - `in_ready`=1.
  - Accepted byte == running XOR: go to PEND.
  - Otherwise: pulse `frame_err`, discard shadow, go to IDLE.
- **PEND**
  - `in_ready`=0.
  - On the first `period_tick` seen while in PEND: `phase_out` <= shadow, `phase_upd`=1, go to IDLE.
- **Timeout**
  - The idle counter clears on every accepted byte and counts every other cycle.
  - In PAYLOAD or CKSUM, when the counter reaches TIMEOUT-1: pulse `frame_err`, go to IDLE.
  - The counter is inactive in IDLE and PEND.
- `busy`=1 in PAYLOAD, CKSUM and PEND.
- `phase_out` changes only on commit. Aborted frames never alter it.

## Timing
- Reset values:
  - `phase_out`=0 (all channels in phase).
  - `phase_upd`=0, `frame_err`=0, `busy`=0.
  - `in_ready`=1; state IDLE; counters and XOR cleared.
- `rst` asserted mid-frame or in PEND: the frame is lost and `phase_out` returns to 0 on the next edge.
- All outputs are registered. `in_ready` is a function of state only, with no combinational path from `in_valid`.
- Commit latency:
  - A `period_tick` sampled in PEND at edge n produces new `phase_out` and `phase_upd`=1 after edge n.
  - A tick coinciding with the final frame byte (the cycle the state is still CKSUM/PAYLOAD) does not commit. The commit waits for the next tick.
- Back-to-back frames: a header accepted in the cycle after commit is legal.
- Throughput: one byte per cycle while `in_ready`=1.
- `frame_err` and `phase_upd` are never high in the same cycle.

## Configuration
- `PHASE_CKSUM_EN`
  - Defined: the frame is HDR + N_CH payload bytes + 1 XOR checksum byte, and CKSUM is used as above.
  - Undefined:
    - The frame is HDR + N_CH payload bytes.
    - PAYLOAD goes directly to PEND after the last byte.
    - CKSUM and the XOR register are not built.
    - `frame_err` fires only on timeout.

## Test plan
- **Reset:** assert `rst` 3 cycles -> `phase_out`=0, `in_ready`=1, `busy`=0, all pulses low.
- **Good frame:** send 0xAA, bytes 0x00..0x0F, XOR 0x00, no tick for 20 cycles -> `in_ready`=0 and `phase_out` unchanged. Then a `period_tick` -> next edge `phase_out[7:0]`=0x00, `phase_out[127:120]`=0x0F, `phase_upd` high for 1 cycle.
- **Bad checksum:** bytes 0x10 x16, checksum 0x01 -> `frame_err` 1 cycle, `phase_out` keeps its previous table, back to IDLE.
- **Timeout:** header + 5 payload bytes, then TIMEOUT idle cycles -> `frame_err` at cycle TIMEOUT-1 after the last byte. A following full frame then commits normally.
- **Noise and tick alignment:** 0x55, 0x13 before the header -> ignored. `period_tick` in the cycle the checksum byte is accepted -> no commit until the next tick 1000 cycles later.
- **Reset mid-PEND:** a frame is pending and `rst` is pulsed -> `phase_out`=0, and the following tick produces no `phase_upd`.
